// File: rtl/detection_pkg.sv
// Shared types for the candidate collection path: coordinate width, FIFO entry and FSM state.
package detection_pkg;

    localparam int unsigned COORD_W = 12;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cand_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } coll_state_t;

endpackage

// File: rtl/cand_fifo.sv
// Synchronous first-word-fall-through FIFO of cand_t entries with flush.
// Pointers carry a wrap bit so full and empty are told apart without a counter.
module cand_fifo
    import detection_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  flush_i,
    input  logic  wen_i,
    input  cand_t wdata_i,
    input  logic  ren_i,
    output cand_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    cand_t            mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wen_i && !full_o) wptr_d = wptr_q + PTR_W'(1);
            if (ren_i && !empty_o) rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wen_i && !full_o && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/candidate_collector.sv
// Captures classifier hits of one frame into a FIFO, then drains them with valid/ready.
// Optional CANDIDATE_COLLECTOR_DEDUP_EN discards a hit equal to the last written entry.
module candidate_collector
    import detection_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_12 = 12,
    parameter int unsigned FIFO_DEPTH    = 64,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_is_candidate,
    input  logic [DATA_WIDTH_12-1:0] i_xcoord,
    input  logic [DATA_WIDTH_12-1:0] i_ycoord,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_WIDTH_12-1:0] o_xcoord,
    output logic [DATA_WIDTH_12-1:0] o_ycoord,
    output logic [CNT_WIDTH-1:0]     o_hit_count,
    output logic [CNT_WIDTH-1:0]     o_drop_count,
    output logic                     o_overflow,
    output logic                     o_frame_done,
    output logic                     o_busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    coll_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 ovf_q, ovf_d;
    cand_t                hit, head;
    logic                 fifo_full, fifo_empty, fifo_wen, fifo_ren;
    logic                 is_dup, drop;

    assign hit = '{x: i_xcoord, y: i_ycoord};

`ifdef CANDIDATE_COLLECTOR_DEDUP_EN
    cand_t last_q, last_d;
    logic  last_vld_q, last_vld_d;

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (i_frame_start) begin
            last_d     = '0;
            last_vld_d = 1'b0;
        end else if (fifo_wen) begin
            last_d     = hit;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (!reset_fpga) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end

    assign is_dup = last_vld_q && (last_q == hit);
`else
    assign is_dup = 1'b0;
`endif

    // i_frame_start outranks everything, including a same-cycle hit or transfer.
    assign fifo_wen = !i_frame_start && i_is_candidate && !is_dup
                      && (state_q == COLLECT) && !fifo_full;
    assign drop     = !i_frame_start && i_is_candidate && !is_dup
                      && !((state_q == COLLECT) && !fifo_full);
    assign fifo_ren = o_valid && i_ready;

    cand_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_fpga),
        .rst_ni  (reset_fpga),
        .flush_i (i_frame_start),
        .wen_i   (fifo_wen),
        .wdata_i (hit),
        .ren_i   (fifo_ren),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_fpga) begin
        if (!reset_fpga) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_frame_start) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (i_frame_end) state_d = DRAIN;
                DRAIN:   if (fifo_empty) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        o_valid      = (state_q == DRAIN) && !fifo_empty;
        o_frame_done = (state_q == DRAIN) && fifo_empty && !i_frame_start;
        o_busy       = (state_q != IDLE);
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (i_frame_start) begin
            hit_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (fifo_wen && hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (!reset_fpga) begin
            hit_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Coordinates are forced to zero whenever no entry is presented.
    assign o_xcoord     = o_valid ? head.x : '0;
    assign o_ycoord     = o_valid ? head.y : '0;
    assign o_hit_count  = hit_cnt_q;
    assign o_drop_count = drop_cnt_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_candidate_collector.sv
// Directed bench for candidate_collector: expected entries are queued at stimulus time and
// popped as the DUT drains them.
module tb_candidate_collector;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } pair_t;

    logic        clk_fpga = 1'b0;
    logic        reset_fpga;
    logic        i_frame_start, i_frame_end, i_is_candidate, i_ready;
    logic [11:0] i_xcoord, i_ycoord;
    logic        o_valid, o_overflow, o_frame_done, o_busy;
    logic [11:0] o_xcoord, o_ycoord;
    logic [7:0]  o_hit_count, o_drop_count;

    pair_t sb[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk_fpga = ~clk_fpga;

    candidate_collector #(
        .DATA_WIDTH_12 (12),
        .FIFO_DEPTH    (64),
        .CNT_WIDTH     (8)
    ) dut (
        .clk_fpga       (clk_fpga),
        .reset_fpga     (reset_fpga),
        .i_frame_start  (i_frame_start),
        .i_frame_end    (i_frame_end),
        .i_is_candidate (i_is_candidate),
        .i_xcoord       (i_xcoord),
        .i_ycoord       (i_ycoord),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_xcoord       (o_xcoord),
        .o_ycoord       (o_ycoord),
        .o_hit_count    (o_hit_count),
        .o_drop_count   (o_drop_count),
        .o_overflow     (o_overflow),
        .o_frame_done   (o_frame_done),
        .o_busy         (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic fs, input logic fe, input logic c,
                         input logic [11:0] x, input logic [11:0] y, input logic rdy);
        @(negedge clk_fpga);
        i_frame_start  = fs;
        i_frame_end    = fe;
        i_is_candidate = c;
        i_xcoord       = x;
        i_ycoord       = y;
        i_ready        = rdy;
        #1;
    endtask

    task automatic hit(input logic [11:0] x, input logic [11:0] y, input bit store);
        drive(1'b0, 1'b0, 1'b1, x, y, 1'b0);
        if (store) sb.push_back({x, y});
    endtask

    task automatic drain(input string tag, input bit toggle, input int budget);
        int          last = -1;
        bit          held = 1'b0;
        bit          done = 1'b0;
        logic [11:0] hx, hy;
        logic        rdy;
        pair_t       e;
        for (int c = 0; c < budget && !done; c++) begin
            rdy = toggle ? ((c % 2) == 0) : 1'b1;
            drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, rdy);
            if (held) begin
                chk({tag, "_hold_x"}, 32'(o_xcoord), 32'(hx));
                chk({tag, "_hold_y"}, 32'(o_ycoord), 32'(hy));
            end
            held = 1'b0;
            if (o_frame_done) begin
                chk({tag, "_done_gap"}, 32'(c - last), 32'd1);
                chk({tag, "_left"}, 32'(sb.size()), 32'd0);
                done = 1'b1;
            end else if (o_valid) begin
                if (rdy) begin
                    if (sb.size() == 0) begin
                        chk({tag, "_extra"}, 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk({tag, "_x"}, 32'(o_xcoord), 32'(e.x));
                        chk({tag, "_y"}, 32'(o_ycoord), 32'(e.y));
                    end
                    last = c;
                end else begin
                    held = 1'b1;
                    hx   = o_xcoord;
                    hy   = o_ycoord;
                end
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dedup_exp;

        // T1: reset with random inputs
        reset_fpga = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_fpga);
            i_frame_start  = 1'($urandom);
            i_frame_end    = 1'($urandom);
            i_is_candidate = 1'($urandom);
            i_xcoord       = 12'($urandom);
            i_ycoord       = 12'($urandom);
            i_ready        = 1'($urandom);
            #1;
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_x", 32'(o_xcoord), 32'd0);
            chk("rst_y", 32'(o_ycoord), 32'd0);
            chk("rst_hits", 32'(o_hit_count), 32'd0);
            chk("rst_drops", 32'(o_drop_count), 32'd0);
            chk("rst_ovf", 32'(o_overflow), 32'd0);
            chk("rst_done", 32'(o_frame_done), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        reset_fpga = 1'b1;

        // T2: basic frame
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        hit(12'd5, 12'd7, 1'b1);
        chk("t2_busy", 32'(o_busy), 32'd1);
        hit(12'd9, 12'd2, 1'b1);
        hit(12'd30, 12'd11, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t2_hits", 32'(o_hit_count), 32'd3);
        drain("t2", 1'b0, 20);
        chk("t2_drops", 32'(o_drop_count), 32'd0);
        chk("t2_ovf", 32'(o_overflow), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t2_idle_busy", 32'(o_busy), 32'd0);

        // T3: overflow
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 70; i++) hit(12'(i + 1), 12'(i + 200), i < 64);
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t3_hits", 32'(o_hit_count), 32'd64);
        chk("t3_drops", 32'(o_drop_count), 32'd6);
        chk("t3_ovf", 32'(o_overflow), 32'd1);
        drain("t3", 1'b0, 200);

        // T4: backpressure
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t4_ovf_cleared", 32'(o_overflow), 32'd1);
        hit(12'd1, 12'd2, 1'b1);
        chk("t4_ovf_clear", 32'(o_overflow), 32'd0);
        hit(12'd3, 12'd4, 1'b1);
        hit(12'd5, 12'd6, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
        drain("t4", 1'b1, 40);
        chk("t4_hits", 32'(o_hit_count), 32'd3);

        // T5: hit with frame end, hit in DRAIN
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        hit(12'd20, 12'd21, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 12'd7, 12'd8, 1'b0);
        sb.push_back({12'd7, 12'd8});
        drive(1'b0, 1'b0, 1'b1, 12'd50, 12'd50, 1'b0);
        drain("t5", 1'b0, 20);
        chk("t5_hits", 32'(o_hit_count), 32'd2);
        chk("t5_drops", 32'(o_drop_count), 32'd1);
        chk("t5_ovf", 32'(o_overflow), 32'd1);

        // T5: frame start abandons a drain
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        hit(12'd10, 12'd10, 1'b1);
        hit(12'd11, 12'd11, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1);
        chk("t5m_valid", 32'(o_valid), 32'd1);
        chk("t5m_x", 32'(o_xcoord), 32'd10);
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t5m_no_done", 32'(o_frame_done), 32'd0);
        sb.delete();
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t5m_valid_off", 32'(o_valid), 32'd0);
        chk("t5m_hits", 32'(o_hit_count), 32'd0);
        chk("t5m_drops", 32'(o_drop_count), 32'd0);
        chk("t5m_busy", 32'(o_busy), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
        drain("t5_empty", 1'b0, 5);

        // T6: dedup
`ifdef CANDIDATE_COLLECTOR_DEDUP_EN
        dedup_exp = 2;
`else
        dedup_exp = 3;
`endif
        drive(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0);
        hit(12'd4, 12'd4, 1'b1);
        hit(12'd4, 12'd4, dedup_exp == 3);
        hit(12'd5, 12'd4, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0);
        chk("t6_hits", 32'(o_hit_count), 32'(dedup_exp));
        chk("t6_drops", 32'(o_drop_count), 32'd0);
        drain("t6", 1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
